lsu_ctrl: RTL and testbench

- Load/store unit directly downstream of the instruction control decoder.
- Consumes the decoder's MemRead, MemWrite and 3-bit load/store select, plus the ALU-computed address and rs2 store data.
- Runs a req/ack handshake with word-addressed data memory: byte-lane alignment, sign/zero extension, misalignment and illegal-combination detection, bus timeout.
- Stalls the pipeline until each access completes.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_ctrl_if.sv | 29 ++
 rtl/lsu_lane_align.sv | 54 +++++
 rtl/lsu_ctrl.sv | 150 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
//============================================================================
// Module : lsu_pkg
// Brief  : Shared encodings, state type and access rule helpers for the LSU.
// Rev    : 1.0  initial release
//============================================================================
package lsu_pkg;

    localparam logic [2:0] LS_B  = 3'd1;
    localparam logic [2:0] LS_H  = 3'd2;
    localparam logic [2:0] LS_W  = 3'd3;
    localparam logic [2:0] LS_BU = 3'd4;
    localparam logic [2:0] LS_HU = 3'd5;

    localparam int BYTE_W    = 8;
    localparam int HALF_W    = 16;
    localparam int WORD_W    = 32;
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    function automatic logic ls_illegal(input logic rd, input logic wr, input logic [2:0] sel);
        logic bad;
        bad = 1'b0;
        if (rd && wr)
            bad = 1'b1;
        else if (rd)
            bad = !(sel inside {LS_B, LS_H, LS_W, LS_BU, LS_HU});
        else if (wr)
            bad = !(sel inside {LS_B, LS_H, LS_W});
        return bad;
    endfunction

    function automatic logic ls_misaligned(input logic [2:0] sel, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (sel)
            LS_H, LS_HU: mis = off[0];
            LS_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
//============================================================================
// Module : lsu_ctrl_if
// Brief  : Word-addressed data memory req/ack bus between LSU and memory.
// Rev    : 1.0  initial release
//============================================================================
interface lsu_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [3:0]            dmem_be;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [DATA_WIDTH-1:0] dmem_rdata;
    logic                  dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
//============================================================================
// Module : lsu_lane_align
// Brief  : Store lane replication / byte enables and load extract / extend.
// Rev    : 1.0  initial release
//============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]           st_sel,
    input  logic [1:0]           st_off,
    input  logic [WORD_W-1:0]    store_data,
    input  logic [2:0]           ld_sel,
    input  logic [1:0]           ld_off,
    input  logic [WORD_W-1:0]    rdata,
    output logic [WORD_W-1:0]    wdata,
    output logic [NUM_LANES-1:0] be,
    output logic [WORD_W-1:0]    load_ext
);

    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;

    always_comb begin
        wdata = store_data;
        be    = 4'b1111;
        case (st_sel)
            LS_B: begin
                wdata = {4{store_data[BYTE_W-1:0]}};
                be    = 4'b0001 << st_off;
            end
            LS_H: begin
                wdata = {2{store_data[HALF_W-1:0]}};
                be    = st_off[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte   = rdata[{ld_off, 3'b000} +: BYTE_W];
        w_half   = ld_off[1] ? rdata[WORD_W-1:HALF_W] : rdata[HALF_W-1:0];
        load_ext = rdata;
        case (ld_sel)
            LS_B:    load_ext = {{(WORD_W-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
            LS_BU:   load_ext = {{(WORD_W-BYTE_W){1'b0}}, w_byte};
            LS_H:    load_ext = {{(WORD_W-HALF_W){w_half[HALF_W-1]}}, w_half};
            LS_HU:   load_ext = {{(WORD_W-HALF_W){1'b0}}, w_half};
            default: load_ext = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
//============================================================================
// Module : lsu_ctrl
// Brief  : Load/store unit: fault detection, req/ack memory access, stall.
// Rev    : 1.0  initial release
//============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            ls_sel,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  misalign_err,
    output logic                  illegal_err,
    output logic                  bus_err,
    lsu_ctrl_if.master            dmem
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t            r_state, w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_req, r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_sel;
    logic [1:0]            r_off;

    logic                  w_req, w_illegal, w_misal;
    logic                  w_accept, w_done, w_timeout, w_stall;
    logic [DATA_WIDTH-1:0] w_wdata, w_load_ext;
    logic [3:0]            w_be;

    assign w_req     = mem_read | mem_write;
    assign w_illegal = ls_illegal(mem_read, mem_write, ls_sel);
    assign w_misal   = ls_misaligned(ls_sel, addr[1:0]);

    // Store lanes follow the live request; load lanes follow the latched one.
    lsu_lane_align u_align (
        .st_sel     (ls_sel),
        .st_off     (addr[1:0]),
        .store_data (store_data),
        .ld_sel     (r_sel),
        .ld_off     (r_off),
        .rdata      (dmem.dmem_rdata),
        .wdata      (w_wdata),
        .be         (w_be),
        .load_ext   (w_load_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_accept  = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req && !w_illegal && !w_misal) begin
                    w_accept = 1'b1;
                    w_stall  = 1'b1;
                    w_next   = BUSY;
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (dmem.dmem_ack) begin
                    w_done = 1'b1;
                    w_next = DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_sel        <= '0;
            r_off        <= '0;
            load_data    <= '0;
            load_valid   <= 1'b0;
            misalign_err <= 1'b0;
            illegal_err  <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            illegal_err  <= (r_state == IDLE) && w_req && w_illegal;
            misalign_err <= (r_state == IDLE) && w_req && !w_illegal && w_misal;
            bus_err      <= w_timeout;
            load_valid   <= w_done && !r_we;
            if (w_accept) begin
                r_req   <= 1'b1;
                r_we    <= mem_write;
                r_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_sel   <= ls_sel;
                r_off   <= addr[1:0];
                r_cnt   <= '0;
            end
            if (w_done) begin
                r_req <= 1'b0;
                if (!r_we)
                    load_data <= w_load_ext;
            end
            if (w_timeout)
                r_req <= 1'b0;
            if ((r_state == BUSY) && !w_done && !w_timeout)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign stall           = w_stall;
    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
//============================================================================
// Module : tb_lsu_ctrl
// Brief  : Directed self-checking bench with a transaction-level LSU model.
// Rev    : 1.0  initial release
//============================================================================
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, mem_read, mem_write;
    logic [2:0]  ls_sel;
    logic [31:0] addr, store_data, load_data;
    logic        stall, load_valid, misalign_err, illegal_err, bus_err;

    lsu_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dmem_bus ();

    lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ls_sel       (ls_sel),
        .addr         (addr),
        .store_data   (store_data),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .misalign_err (misalign_err),
        .illegal_err  (illegal_err),
        .bus_err      (bus_err),
        .dmem         (dmem_bus)
    );

    int n_pass = 0, n_total = 0;
    int stall_cnt = 0, req_cnt = 0, lv_cnt = 0;

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_lv, exp_mis, exp_ill, exp_bus, exp_req;
    logic        exp_chk_bus, exp_chk_lanes, exp_we;
    logic [31:0] exp_addr, exp_wdata, m_load;
    logic [3:0]  exp_be;

    logic        pin_en = 1'b0;
    int          pin_sel;
    logic [31:0] pin_mark, pin_exp;
    string       pin_name;

    // ---------------- specification-level model ----------------
    function automatic int size_of(input logic [2:0] sel);
        if (sel == 3'd3) return 4;
        if (sel == 3'd2 || sel == 3'd5) return 2;
        return 1;
    endfunction

    // 0 = ok, 1 = illegal, 2 = misaligned
    function automatic int fault_of(input logic rd, input logic wr, input logic [2:0] sel, input logic [1:0] off);
        if (rd && wr) return 1;
        if (rd && !(sel >= 3'd1 && sel <= 3'd5)) return 1;
        if (wr && !(sel >= 3'd1 && sel <= 3'd3)) return 1;
        if (int'(off) % size_of(sel) != 0) return 2;
        return 0;
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] sel, input logic [1:0] off);
        int sz = size_of(sel);
        int base = int'(off) - int'(off) % sz;
        logic [3:0] m;
        m = 4'((1 << sz) - 1);
        return m << base;
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] sel, input logic [31:0] sd);
        int sz = size_of(sel);
        if (sz == 1) return 32'(sd[7:0]) * 32'h0101_0101;
        if (sz == 2) return 32'(sd[15:0]) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] ext_of(input logic [2:0] sel, input logic [1:0] off, input logic [31:0] rd);
        int sz = size_of(sel);
        int base = int'(off) - int'(off) % sz;
        logic [63:0] v, lim;
        v   = 64'(rd) >> (8 * base);
        lim = 64'd1 << (8 * sz);
        v   = v % lim;
        if ((sel == 3'd1 || sel == 3'd2) && v >= lim / 2)
            v = v - lim;
        return v[31:0];
    endfunction

    // ---------------- compare process ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",        32'(stall),        32'(exp_stall));
            chk("load_valid",   32'(load_valid),   32'(exp_lv));
            chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
            chk("illegal_err",  32'(illegal_err),  32'(exp_ill));
            chk("bus_err",      32'(bus_err),      32'(exp_bus));
            chk("dmem_req",     32'(dmem_bus.dmem_req), 32'(exp_req));
            chk("load_data",    load_data, m_load);
            if (exp_chk_bus) begin
                chk("dmem_we",   32'(dmem_bus.dmem_we), 32'(exp_we));
                chk("dmem_addr", dmem_bus.dmem_addr, exp_addr);
            end
            if (exp_chk_lanes) begin
                chk("dmem_be",    32'(dmem_bus.dmem_be), 32'(exp_be));
                chk("dmem_wdata", dmem_bus.dmem_wdata, exp_wdata);
            end
            if (pin_en) begin
                case (pin_sel)
                    0:       chk(pin_name, load_data, pin_exp);
                    1:       chk(pin_name, 32'(stall_cnt) - pin_mark, pin_exp);
                    2:       chk(pin_name, 32'(req_cnt) - pin_mark, pin_exp);
                    default: chk(pin_name, 32'(lv_cnt) - pin_mark, pin_exp);
                endcase
            end
            if (stall === 1'b1)             stall_cnt++;
            if (dmem_bus.dmem_req === 1'b1) req_cnt++;
            if (load_valid === 1'b1)        lv_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_idle_exp();
        exp_stall = 1'b0; exp_lv = 1'b0; exp_mis = 1'b0; exp_ill = 1'b0;
        exp_bus = 1'b0; exp_req = 1'b0; exp_chk_bus = 1'b0; exp_chk_lanes = 1'b0;
    endtask

    task automatic set_zero_exp();
        set_idle_exp();
        exp_chk_bus = 1'b1; exp_chk_lanes = 1'b1;
        exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wdata = '0;
    endtask

    task automatic drive_idle();
        mem_read = 1'b0; mem_write = 1'b0; ls_sel = 3'd0;
        addr = $urandom; store_data = $urandom;
        dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = $urandom;
    endtask

    task automatic drive_garbage();
        mem_read = 1'($urandom); mem_write = 1'($urandom); ls_sel = 3'($urandom);
        addr = $urandom; store_data = $urandom;
    endtask

    // ack_after: BUSY cycle index carrying ack, or -1 for no ack at all
    task automatic access(input logic rd, input logic wr, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdat, input int ack_after);
        int f;
        bit acked;
        f = fault_of(rd, wr, sel, a[1:0]);
        acked = 1'b0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; ls_sel = sel; addr = a; store_data = sd;
        dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = $urandom;
        set_idle_exp();
        exp_stall = (f == 0);
        @(posedge clk); #1;
        if (f != 0) begin
            drive_idle();
            set_idle_exp();
            exp_ill = (f == 1);
            exp_mis = (f == 2);
        end else begin
            for (int i = 0; i < TO && !acked; i++) begin
                drive_garbage();
                dmem_bus.dmem_ack   = (i == ack_after);
                dmem_bus.dmem_rdata = (i == ack_after) ? rdat : $urandom;
                set_idle_exp();
                exp_stall = 1'b1; exp_req = 1'b1; exp_chk_bus = 1'b1;
                exp_we = wr; exp_addr = a & 32'hFFFF_FFFC;
                exp_chk_lanes = wr; exp_be = be_of(sel, a[1:0]); exp_wdata = wdata_of(sel, sd);
                acked = (i == ack_after);
                @(posedge clk); #1;
            end
            drive_idle();
            dmem_bus.dmem_ack = 1'b1;
            set_idle_exp();
            if (acked) begin
                if (rd) begin
                    m_load = ext_of(sel, a[1:0], rdat);
                    exp_lv = 1'b1;
                end
            end else begin
                exp_bus = 1'b1;
            end
        end
        @(posedge clk); #1;
        drive_idle();
        set_idle_exp();
    endtask

    task automatic pin(input string nm, input int sel, input logic [31:0] mark, input logic [31:0] exp);
        pin_name = nm; pin_sel = sel; pin_mark = mark; pin_exp = exp;
        pin_en = 1'b1;
        @(negedge clk); #1;
        pin_en = 1'b0;
    endtask

    task automatic reset_mid_busy();
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; ls_sel = LS_W; addr = 32'h600;
        dmem_bus.dmem_ack = 1'b0;
        set_idle_exp(); exp_stall = 1'b1;
        @(posedge clk); #1;
        drive_garbage();
        set_idle_exp();
        exp_stall = 1'b1; exp_req = 1'b1; exp_chk_bus = 1'b1; exp_we = 1'b0; exp_addr = 32'h600;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_idle();
        dmem_bus.dmem_ack = 1'b1;
        m_load = '0;
        set_zero_exp();
        @(posedge clk); #1;
        drive_idle();
        set_zero_exp();
    endtask

    initial begin
        logic [31:0] mark_s, mark_r, mark_l;
        rst_n = 1'b0;
        drive_idle();
        set_zero_exp();
        m_load = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        mark_s = 32'(stall_cnt); mark_l = 32'(lv_cnt);
        access(1'b0, 1'b1, LS_B, 32'h103, 32'h0000_00A5, 32'h0, 1);
        pin("sb_stall_cycles", 1, mark_s, 32'd3);
        pin("sb_no_load_valid", 3, mark_l, 32'd0);

        access(1'b1, 1'b0, LS_B, 32'h202, 32'h0, 32'h0080_0000, 0);
        pin("lb_load_data", 0, 32'h0, 32'hFFFF_FF80);
        access(1'b1, 1'b0, LS_BU, 32'h202, 32'h0, 32'h0080_0000, 0);
        pin("lbu_load_data", 0, 32'h0, 32'h0000_0080);

        mark_r = 32'(req_cnt); mark_s = 32'(stall_cnt);
        access(1'b1, 1'b0, LS_H, 32'h301, 32'h0, 32'h0, 0);
        access(1'b1, 1'b0, LS_W, 32'h302, 32'h0, 32'h0, 0);
        access(1'b1, 1'b1, LS_W, 32'h010, 32'h0, 32'h0, 0);
        access(1'b1, 1'b0, 3'd6, 32'h020, 32'h0, 32'h0, 0);
        access(1'b0, 1'b1, 3'd4, 32'h030, 32'h0, 32'h0, 0);
        pin("faults_no_req", 2, mark_r, 32'd0);
        pin("faults_no_stall", 1, mark_s, 32'd0);

        access(1'b0, 1'b1, LS_H, 32'h0A2, 32'h1234_5678, 32'h0, 0);
        access(1'b0, 1'b1, LS_W, 32'h0F0, 32'hDEAD_BEEF, 32'h0, 2);
        access(1'b1, 1'b0, LS_H, 32'h702, 32'h0, 32'h8001_1234, 1);
        pin("lh_load_data", 0, 32'h0, 32'hFFFF_8001);
        access(1'b1, 1'b0, LS_W, 32'h800, 32'h0, 32'hCAFE_F00D, 3);
        access(1'b1, 1'b0, LS_BU, 32'h103, 32'h0, 32'h9A00_0000, 0);

        mark_r = 32'(req_cnt);
        access(1'b1, 1'b0, LS_W, 32'h400, 32'h0, 32'h0, -1);
        pin("timeout_req_cycles", 2, mark_r, 32'd16);

        reset_mid_busy();
        access(1'b1, 1'b0, LS_HU, 32'h502, 32'h0, 32'hBEEF_0000, 0);
        pin("lhu_load_data", 0, 32'h0, 32'h0000_BEEF);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
